// File: rtl/cmp_pkg.sv
// Shared types and helpers for the serial compare unit.
//   cmp_mode_t  : operation select (SLT, SLTU, SEQ, SGE)
//   cmp_state_t : controller states (IDLE, RUN, DONE)
//   is_signed() : true for every mode that compares two's-complement values
package cmp_pkg;

    typedef enum logic [1:0] {
        SLT  = 2'b00,
        SLTU = 2'b01,
        SEQ  = 2'b10,
        SGE  = 2'b11
    } cmp_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cmp_state_t;

    // Only SLTU treats operands as unsigned; SEQ is sign-agnostic, so biasing is harmless.
    function automatic logic is_signed(input cmp_mode_t mode);
        return mode != SLTU;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational K-bit unsigned magnitude compare of one operand slice.
//   a, b     : K-bit slices (most significant remaining bits of each operand)
//   slice_lt : a < b
//   slice_eq : a == b
module cmp_slice #(
    parameter int unsigned K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         slice_lt,
    output logic         slice_eq
);

    assign slice_lt = (a < b);
    assign slice_eq = (a == b);

endmodule

// File: rtl/slt_serial_cmp.sv
// Multi-cycle compare unit: r2 vs r3, MSB-first, K bits per clock, start/busy/done handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request, accepted whenever busy=0 (IDLE or DONE)
//   mode          : 00 SLT, 01 SLTU, 10 SEQ, 11 SGE (latched on accept)
//   r2, r3        : operands (latched on accept)
//   r1            : {N-1 zeros, result bit}
//   lt, eq, gt    : r2 vs r3 flags (signed except in SLTU)
//   busy          : comparison in progress
//   done          : one-cycle pulse, results valid
module slt_serial_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [N-1:0] r2,
    input  logic [N-1:0] r3,
    output logic [N-1:0] r1,
    output logic         lt,
    output logic         eq,
    output logic         gt,
    output logic         busy,
    output logic         done
);

    // Parameter legality is checked at elaboration.
    generate
        if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
            $error("slt_serial_cmp: need N >= 2, 1 <= K <= N and N %% K == 0");
        end
    endgenerate

    localparam int unsigned SLICES = N / K;
    localparam int unsigned CW     = $clog2(SLICES) + 1;

    cmp_state_t     state;
    cmp_mode_t      mode_q;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [CW-1:0]  cnt;
    logic           decided;
    logic           dlt;

    logic           slice_lt;
    logic           slice_eq;
    logic           fin_lt;
    logic           fin_eq;
    logic           fin_gt;
    logic           fin_bit;
    logic           sgn;

    // Compare the top K bits of the shift registers this cycle.
    cmp_slice #(.K(K)) u_slice (
        .a        (a[N-1 -: K]),
        .b        (b[N-1 -: K]),
        .slice_lt (slice_lt),
        .slice_eq (slice_eq)
    );

    // Final result as seen at the last slice: an earlier decision wins over this slice.
    always_comb begin
        fin_lt  = decided ? dlt : slice_lt;
        fin_eq  = !decided && slice_eq;
        fin_gt  = !fin_lt && !fin_eq;
        fin_bit = 1'b0;
        case (mode_q)
            SLT, SLTU: fin_bit = fin_lt;
            SEQ:       fin_bit = fin_eq;
            default:   fin_bit = !fin_lt;
        endcase
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sgn = is_signed(cmp_mode_t'(mode));

    // Controller, shift registers, sticky decision and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode_q  <= SLT;
            a       <= '0;
            b       <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dlt     <= 1'b0;
            r1      <= '0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q  <= cmp_mode_t'(mode);
                        a       <= {r2[N-1] ^ sgn, r2[N-2:0]};
                        b       <= {r3[N-1] ^ sgn, r3[N-2:0]};
                        cnt     <= CW'(SLICES - 1);
                        decided <= 1'b0;
                        dlt     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (!decided && !slice_eq) begin
                        decided <= 1'b1;
                        dlt     <= slice_lt;
                    end
                    a <= a << K;
                    b <= b << K;
                    if (cnt == '0) begin
                        r1    <= {{(N-1){1'b0}}, fin_bit};
                        lt    <= fin_lt;
                        eq    <= fin_eq;
                        gt    <= fin_gt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/slt_serial_cmp.md
# slt_serial_cmp

Multi-cycle, parameterised compare unit: the sequential successor of the single-cycle set-less-than block. It compares r2 against r3 MSB-first, K bits per clock, under a start/busy/done handshake. It supports signed and unsigned less-than, equality and signed greater-or-equal, with a full-width r1 result plus lt/eq/gt flags. It sits beside the ALU as the compare path for multi-cycle execution, trading latency for a narrow per-cycle comparator.

## Interface
- N, 32, operand and result width; N >= 2.
- K, 4, bits compared per cycle; 1 <= K <= N and N % K == 0 (elaboration error otherwise).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- mode  in  2  00 SLT signed, 01 SLTU unsigned, 10 SEQ, 11 SGE signed; latched with start.
- r2  in  N  left operand; latched with start.
- r3  in  N  right operand; latched with start.
- r1  out  N  result {N-1 zeros, bit}; bit = lt (SLT/SLTU), eq (SEQ), !lt (SGE).
- lt, eq, gt  out  1 each  flags for r2 vs r3 (unsigned only for SLTU, signed otherwise); exactly one is high when valid.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse; results valid.

## Operation
- States: IDLE, RUN, DONE.
- Signed handling:
  - On accept, the MSB of each latched operand is inverted when mode != 01.
  - An unsigned compare of the biased values equals the signed compare.
  - No subtraction, so no overflow case exists: 0x7fffffff vs 0x80000001 is always correct.
- RUN:
  - Each cycle compares the top K bits of the shift registers a and b, then shifts both left by K.
  - Slice counter starts at N/K-1 and decrements.
  - A sticky decided flag latches the slice-level lt/gt on the first unequal slice; later slices are ignored.
- End of the last slice:
  - If undecided, eq=1.
  - Flags and r1 register, state -> DONE.
- DONE lasts one cycle, then IDLE. r1 and the flags hold their values until the next accepted start.
- start while busy=1 is ignored; there is no queueing.
- start in DONE is accepted; this is a back-to-back operation.
- Accepting a start clears nothing visible: r1 and the flags keep the prior result until the new done.

## Timing
- Reset values: r1=0, lt=0, eq=0, gt=0, busy=0, done=0, state IDLE, counter 0.
- Reset mid-RUN aborts immediately to the reset values; the partial result is discarded.
- Latency (start sampled high at edge E0):
  - busy=1 after E0.
  - Slices processed at E1..E(N/K).
  - After E(N/K): busy=0, done=1, r1 and flags valid.
  - After E(N/K+1): done=0.
  - Default latency is 8 cycles start-to-done.
- Throughput: one compare per N/K+1 cycles when start is held high continuously (accepted in DONE).
- K=N degenerates to a 1-cycle RUN; done follows 2 edges after start.
- r2, r3 and mode may change freely after the accept edge.

## Structure
- Shared package cmp_pkg:
  - cmp_mode_t enum: SLT, SLTU, SEQ, SGE.
  - cmp_state_t enum: IDLE, RUN, DONE.
  - Helper function is_signed(mode).
- Sub-module cmp_slice, parameter K: combinational K-bit unsigned compare producing slice_lt and slice_eq. One instance.
- Top: FSM, operand shift registers, slice counter (width $clog2(N/K)+1), sticky decision, output registers.

## Test plan
- SLT, r2=0xffffffff, r3=0x00000005 -> after 8 cycles done=1, r1=1, lt=1. Same operands in SLTU -> r1=0, gt=1.
- SLT, r2=0x7fffffff, r3=0x80000001 -> r1=0, gt=1. SGE with the same operands -> r1=1.
- SEQ, r2=r3=0xffffffff -> r1=1, eq=1. SEQ, r2=0xfffffffe, r3=0xffffffff -> r1=0, lt=1. The decision falls in the last slice.
- Early decision: SLT, r2=0xffff0000, r3=0xfffffffe.
  - Differing first slice at bit 15 -> r1=1.
  - Lower slices must not override; check r2=0x10000000, r3=0x0fffffff -> gt=1.
- Handshake:
  - start pulsed again on cycles 2-5 of a run -> ignored; done exactly once, at cycle 8.
  - start held high -> done pulses every 9 cycles with correct alternating results when operands change.
- Reset asserted in cycle 4 of a run -> all outputs 0 immediately. A new start after release completes normally in 8 cycles.
- Sweep: N=8 with K=1, 2, 4, 8, all 65536 operand pairs in SLT and SLTU -> r1 matches the reference (r2<r3).
